cache_fsm_l1d_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate L1 data cache controller with true-LRU replacement.
- Sits between the processor request port and the L2 cache FSM.
- Serves reads and writes for one processor ID.
- Writes dirty victims back to L2 and refills whole lines from L2.
- Keeps saturating hit and miss counters for performance analysis.

---
 rtl/cache_fsm_l1d_assoc.sv | 209 ++++++++++++++++++++
 tb/tb_cache_fsm_l1d_assoc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fsm_l1d_assoc.sv
// N-way set-associative write-back/write-allocate L1D controller with true-LRU
// replacement, dirty-victim write-back to L2 and whole-line refill.

module cache_fsm_l1d_assoc_way_cmp #(
  parameter int TAG_W = 22
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] way_tag,
  input  logic [TAG_W-1:0] req_tag,
  output logic             hit
);
  assign hit = valid && (way_tag == req_tag);
endmodule

module cache_fsm_l1d_assoc #(
  parameter int         ADDRESS_WIDTH  = 32,
  parameter int         DATA_WIDTH     = 32,
  parameter int         WORDS_PER_LINE = 4,
  parameter int         NUM_SETS       = 16,
  parameter int         NUM_WAYS       = 2,
  parameter logic [1:0] PROCESSOR_ID   = 2'd3,
  parameter int         COUNTER_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cache_read_request,
  input  logic                               cache_write_request,
  input  logic [ADDRESS_WIDTH-1:0]           cache_L1_memory_address,
  input  logic [DATA_WIDTH-1:0]              cache_write_data,
  output logic [DATA_WIDTH-1:0]              cache_L1_read_data,
  output logic                               L1_cache_ready,
  output logic                               L1_cache_hit,
  output logic                               L1_cache_miss,
  output logic [ADDRESS_WIDTH-1:0]           cache_L2_memory_address,
  output logic                               read_from_L2_request,
  input  logic                               L2_ready,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] write_data_to_L1_from_L2,
  output logic                               write_back_to_L2_request,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] write_back_to_L2_data,
  input  logic                               write_back_to_L2_verified,
  output logic [COUNTER_WIDTH-1:0]           hit_count,
  output logic [COUNTER_WIDTH-1:0]           miss_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDRESS_WIDTH - 4 - OFF_W - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE, RESPOND} state_t;
  typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;
  typedef struct packed {
    logic                     wr;
    logic [ADDRESS_WIDTH-3:0] addr;   // word address; byte bits dropped
    logic [DATA_WIDTH-1:0]    wdata;
  } req_t;

  state_t state;
  req_t   req_q;
  logic   first_cmp;
  logic [WAY_W-1:0] victim_q;

  logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_mem  [NUM_WAYS][NUM_SETS];
  line_t            line_mem [NUM_WAYS][NUM_SETS];
  logic [WAY_W-1:0] age_q    [NUM_SETS][NUM_WAYS];

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [ADDRESS_WIDTH-1:0] line_addr;
  assign req_off   = req_q.addr[0 +: OFF_W];
  assign req_idx   = req_q.addr[OFF_W +: IDX_W];
  assign req_tag   = req_q.addr[OFF_W+IDX_W +: TAG_W];
  assign line_addr = {req_q.addr[ADDRESS_WIDTH-3:OFF_W], {(OFF_W+2){1'b0}}};

  logic unused_byte_bits;
  assign unused_byte_bits = ^cache_L1_memory_address[1:0];

  logic [NUM_WAYS-1:0] way_hit;
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_fsm_l1d_assoc_way_cmp #(.TAG_W(TAG_W)) u_cmp (
      .valid   (valid_q[w][req_idx]),
      .way_tag (tag_mem[w][req_idx]),
      .req_tag (req_tag),
      .hit     (way_hit[w])
    );
  end

  // Descending scans so the lowest index wins; an invalid way beats the LRU way.
  logic [WAY_W-1:0] hit_way, victim;
  always_comb begin
    hit_way = '0;
    victim  = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (way_hit[w]) hit_way = WAY_W'(w);
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (age_q[req_idx][w] == WAY_W'(NUM_WAYS-1)) victim = WAY_W'(w);
    for (int w = NUM_WAYS-1; w >= 0; w--)
      if (!valid_q[w][req_idx]) victim = WAY_W'(w);
  end

  line_t hit_line;
  assign hit_line = line_mem[hit_way][req_idx];

  // Data/tag arrays carry no reset; validity is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (state == COMPARE && |way_hit && req_q.wr)
      line_mem[hit_way][req_idx][req_off] <= req_q.wdata;
    if (state == ALLOCATE && L2_ready) begin
      line_mem[victim_q][req_idx] <= write_data_to_L1_from_L2;
      tag_mem[victim_q][req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                    <= IDLE;
      req_q                    <= '0;
      first_cmp                <= 1'b0;
      victim_q                 <= '0;
      valid_q                  <= '0;
      dirty_q                  <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
      hit_count                <= '0;
      miss_count               <= '0;
      cache_L1_read_data       <= '0;
      L1_cache_ready           <= 1'b0;
      L1_cache_hit             <= 1'b0;
      L1_cache_miss            <= 1'b0;
      cache_L2_memory_address  <= '0;
      read_from_L2_request     <= 1'b0;
      write_back_to_L2_request <= 1'b0;
      write_back_to_L2_data    <= '0;
    end else begin
      L1_cache_ready <= 1'b0;
      L1_cache_hit   <= 1'b0;
      L1_cache_miss  <= 1'b0;
      case (state)
        IDLE: begin
          if ((cache_read_request || cache_write_request) &&
              cache_L1_memory_address[ADDRESS_WIDTH-1 -: 2] == PROCESSOR_ID) begin
            req_q.wr    <= cache_write_request;
            req_q.addr  <= cache_L1_memory_address[ADDRESS_WIDTH-1:2];
            req_q.wdata <= cache_write_data;
            first_cmp   <= 1'b1;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          first_cmp <= 1'b0;
          if (|way_hit) begin
            if (first_cmp) begin
              L1_cache_hit <= 1'b1;
              if (~&hit_count) hit_count <= hit_count + 1'b1;
            end
            if (req_q.wr) dirty_q[hit_way][req_idx] <= 1'b1;
            else          cache_L1_read_data        <= hit_line[req_off];
            for (int w = 0; w < NUM_WAYS; w++) begin
              if (WAY_W'(w) == hit_way)
                age_q[req_idx][w] <= '0;
              else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
                age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
            end
            L1_cache_ready <= 1'b1;
            state          <= RESPOND;
          end else begin
            if (first_cmp) begin
              L1_cache_miss <= 1'b1;
              if (~&miss_count) miss_count <= miss_count + 1'b1;
            end
            victim_q <= victim;
            if (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) begin
              write_back_to_L2_request <= 1'b1;
              write_back_to_L2_data    <= line_mem[victim][req_idx];
              cache_L2_memory_address  <= {PROCESSOR_ID, tag_mem[victim][req_idx], req_idx,
                                           {(OFF_W+2){1'b0}}};
              state                    <= WRITE_BACK;
            end else begin
              read_from_L2_request    <= 1'b1;
              cache_L2_memory_address <= line_addr;
              state                   <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (write_back_to_L2_verified) begin
            write_back_to_L2_request   <= 1'b0;
            dirty_q[victim_q][req_idx] <= 1'b0;
            read_from_L2_request       <= 1'b1;
            cache_L2_memory_address    <= line_addr;
            state                      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (L2_ready) begin
            read_from_L2_request       <= 1'b0;
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
            state                      <= COMPARE;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_fsm_l1d_assoc.sv
// Directed bench for cache_fsm_l1d_assoc: 2-way, 16 sets, 4-word lines, 4-bit counters,
// with a delay-programmable L2 responder.

module tb_cache_fsm_l1d_assoc;
  logic         clk, reset;
  logic         cache_read_request, cache_write_request;
  logic [31:0]  cache_L1_memory_address, cache_write_data, cache_L1_read_data;
  logic         L1_cache_ready, L1_cache_hit, L1_cache_miss;
  logic [31:0]  cache_L2_memory_address;
  logic         read_from_L2_request, L2_ready;
  logic [127:0] write_data_to_L1_from_L2, write_back_to_L2_data;
  logic         write_back_to_L2_request, write_back_to_L2_verified;
  logic [3:0]   hit_count, miss_count;

  int errors = 0, checks = 0;
  int l2_delay = 3, wb_delay = 4;
  logic [127:0] l2_line = '0;
  int rd_cnt = 0, wb_cnt = 0, rd_reqs = 0, wb_reqs = 0, wb_held = 0;
  logic [31:0]  rd_addr = '0, wb_addr = '0;
  logic [127:0] wb_data = '0;
  bit wb_unstable = 0, both_seen = 0;

  cache_fsm_l1d_assoc #(.COUNTER_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cache_read_request(cache_read_request), .cache_write_request(cache_write_request),
    .cache_L1_memory_address(cache_L1_memory_address), .cache_write_data(cache_write_data),
    .cache_L1_read_data(cache_L1_read_data), .L1_cache_ready(L1_cache_ready),
    .L1_cache_hit(L1_cache_hit), .L1_cache_miss(L1_cache_miss),
    .cache_L2_memory_address(cache_L2_memory_address),
    .read_from_L2_request(read_from_L2_request), .L2_ready(L2_ready),
    .write_data_to_L1_from_L2(write_data_to_L1_from_L2),
    .write_back_to_L2_request(write_back_to_L2_request),
    .write_back_to_L2_data(write_back_to_L2_data),
    .write_back_to_L2_verified(write_back_to_L2_verified),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // L2 model: answers after l2_delay / wb_delay falling edges of a held request.
  initial begin
    L2_ready = 0; write_back_to_L2_verified = 0; write_data_to_L1_from_L2 = '0;
    forever begin
      @(negedge clk);
      if (read_from_L2_request && write_back_to_L2_request) both_seen = 1;
      if (read_from_L2_request === 1'b1) begin
        if (rd_cnt == 0) begin rd_reqs++; rd_addr = cache_L2_memory_address; end
        rd_cnt++;
        write_data_to_L1_from_L2 = l2_line;
        L2_ready = (rd_cnt >= l2_delay);
      end else begin
        rd_cnt = 0; L2_ready = 0;
      end
      if (write_back_to_L2_request === 1'b1) begin
        if (wb_cnt == 0) begin
          wb_reqs++; wb_addr = cache_L2_memory_address; wb_data = write_back_to_L2_data;
        end else if (cache_L2_memory_address !== wb_addr || write_back_to_L2_data !== wb_data)
          wb_unstable = 1;
        wb_cnt++;
        wb_held = wb_cnt;
        write_back_to_L2_verified = (wb_cnt >= wb_delay);
      end else begin
        wb_cnt = 0; write_back_to_L2_verified = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     output int lat, output bit h, output bit m, output logic [31:0] rd);
    @(negedge clk);
    cache_write_request = wr; cache_read_request = !wr;
    cache_L1_memory_address = addr; cache_write_data = wd;
    @(posedge clk); #1;
    cache_write_request = 0; cache_read_request = 0;
    lat = 0; h = 0; m = 0;
    while (L1_cache_ready !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (L1_cache_hit === 1'b1) h = 1;
      if (L1_cache_miss === 1'b1) m = 1;
    end
    rd = cache_L1_read_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 0;
    #12;
    checks++; if (hit_count !== 4'd0 || miss_count !== 4'd0) begin errors++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); end
    checks++; if ({L1_cache_ready, L1_cache_hit, L1_cache_miss, read_from_L2_request,
                   write_back_to_L2_request} !== 5'b0) begin errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {L1_cache_ready, L1_cache_hit,
               L1_cache_miss, read_from_L2_request, write_back_to_L2_request}); end
    checks++; if (cache_L1_read_data !== 32'h0 || cache_L2_memory_address !== 32'h0 ||
                  write_back_to_L2_data !== 128'h0) begin errors++;
      $display("FAIL reset_buses: got rd=%h l2a=%h wbd=%h expected zeros", cache_L1_read_data,
               cache_L2_memory_address, write_back_to_L2_data); end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_read_miss();
    int lat; bit h, m; logic [31:0] rd;
    l2_line = {32'd4, 32'd3, 32'd2, 32'd1}; l2_delay = 3;
    txn(0, 32'hC000_0010, 32'h0, lat, h, m, rd);
    checks++; if (m !== 1'b1 || h !== 1'b0) begin errors++;
      $display("FAIL read_miss_pulse: got hit=%0b miss=%0b expected hit=0 miss=1", h, m); end
    checks++; if (lat != 5) begin errors++;
      $display("FAIL read_miss_latency: got %0d expected 5", lat); end
    checks++; if (rd !== 32'h1) begin errors++;
      $display("FAIL read_miss_data: got %h expected 00000001", rd); end
    checks++; if (rd_addr !== 32'hC000_0010) begin errors++;
      $display("FAIL refill_addr: got %h expected c0000010", rd_addr); end
    checks++; if (miss_count !== 4'd1 || hit_count !== 4'd0) begin errors++;
      $display("FAIL read_miss_counts: got hit=%0d miss=%0d expected 0/1", hit_count, miss_count); end
    txn(0, 32'hC000_0014, 32'h0, lat, h, m, rd);
    checks++; if (h !== 1'b1 || m !== 1'b0 || lat != 1) begin errors++;
      $display("FAIL offset1_hit: got hit=%0b miss=%0b lat=%0d expected 1/0/1", h, m, lat); end
    checks++; if (rd !== 32'h2) begin errors++;
      $display("FAIL offset1_data: got %h expected 00000002", rd); end
  endtask

  task automatic test_write_hit();
    int lat; bit h, m; logic [31:0] rd;
    txn(1, 32'hC000_0010, 32'hDEAD_BEEF, lat, h, m, rd);
    checks++; if (h !== 1'b1 || m !== 1'b0 || lat != 1) begin errors++;
      $display("FAIL write_hit: got hit=%0b miss=%0b lat=%0d expected 1/0/1", h, m, lat); end
    txn(0, 32'hC000_0010, 32'h0, lat, h, m, rd);
    checks++; if (rd !== 32'hDEAD_BEEF || h !== 1'b1) begin errors++;
      $display("FAIL read_after_write: got %h hit=%0b expected deadbeef hit=1", rd, h); end
    checks++; if (hit_count !== 4'd3 || rd_reqs != 1 || wb_reqs != 0) begin errors++;
      $display("FAIL write_hit_counts: got hits=%0d rd_reqs=%0d wb_reqs=%0d expected 3/1/0",
               hit_count, rd_reqs, wb_reqs); end
  endtask

  task automatic test_evict();
    int lat; bit h, m; logic [31:0] rd;
    l2_line = {32'd8, 32'd7, 32'd6, 32'd5};
    txn(1, 32'hC000_1010, 32'h1234_5678, lat, h, m, rd);
    checks++; if (m !== 1'b1 || lat != 5) begin errors++;
      $display("FAIL write_miss: got miss=%0b lat=%0d expected 1/5", m, lat); end
    txn(0, 32'hC000_0010, 32'h0, lat, h, m, rd);
    checks++; if (h !== 1'b1 || rd !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL touch_way0: got hit=%0b rd=%h expected 1/deadbeef", h, rd); end
    l2_line = {32'hC, 32'hB, 32'hA, 32'h9};
    txn(0, 32'hC000_2010, 32'h0, lat, h, m, rd);
    checks++; if (m !== 1'b1 || lat != 9) begin errors++;
      $display("FAIL dirty_miss: got miss=%0b lat=%0d expected 1/9", m, lat); end
    checks++; if (wb_addr !== 32'hC000_1010) begin errors++;
      $display("FAIL wb_addr: got %h expected c0001010", wb_addr); end
    checks++; if (wb_data !== {32'd8, 32'd7, 32'd6, 32'h1234_5678}) begin errors++;
      $display("FAIL wb_data: got %h expected 000000080000000700000006" , wb_data,
               "12345678"); end
    checks++; if (wb_held != 4 || wb_unstable !== 1'b0 || wb_reqs != 1) begin errors++;
      $display("FAIL wb_hold: got held=%0d unstable=%0b reqs=%0d expected 4/0/1",
               wb_held, wb_unstable, wb_reqs); end
    checks++; if (rd !== 32'h9) begin errors++;
      $display("FAIL refill_way1_data: got %h expected 00000009", rd); end
    l2_line = {32'd8, 32'd7, 32'd6, 32'd5};
    txn(0, 32'hC000_1010, 32'h0, lat, h, m, rd);
    checks++; if (m !== 1'b1 || wb_addr !== 32'hC000_0010 ||
                  wb_data !== {32'd4, 32'd3, 32'd2, 32'hDEAD_BEEF}) begin errors++;
      $display("FAIL lru_second_evict: got miss=%0b addr=%h data=%h expected 1/c0000010/deadbeef line",
               m, wb_addr, wb_data); end
    checks++; if (rd !== 32'h5 || hit_count !== 4'd4 || miss_count !== 4'd4 || both_seen) begin errors++;
      $display("FAIL evict_summary: got rd=%h hits=%0d misses=%0d both=%0b expected 5/4/4/0",
               rd, hit_count, miss_count, both_seen); end
  endtask

  task automatic test_foreign_id();
    int lat; bit h, m, bad; logic [31:0] rd;
    bad = 0;
    @(negedge clk);
    cache_read_request = 1; cache_L1_memory_address = 32'h8000_0000;
    repeat (4) begin
      @(posedge clk); #1;
      if (L1_cache_ready || L1_cache_hit || L1_cache_miss || read_from_L2_request ||
          write_back_to_L2_request) bad = 1;
    end
    cache_read_request = 0;
    checks++; if (bad) begin errors++;
      $display("FAIL foreign_id_activity: got activity=1 expected 0"); end
    checks++; if (hit_count !== 4'd4 || miss_count !== 4'd4 || rd_reqs != 4) begin errors++;
      $display("FAIL foreign_id_counts: got hits=%0d misses=%0d rd_reqs=%0d expected 4/4/4",
               hit_count, miss_count, rd_reqs); end
    txn(0, 32'hC000_2010, 32'h0, lat, h, m, rd);
    checks++; if (h !== 1'b1 || lat != 1 || rd !== 32'h9) begin errors++;
      $display("FAIL after_foreign_hit: got hit=%0b lat=%0d rd=%h expected 1/1/9", h, lat, rd); end
  endtask

  task automatic test_reset_mid();
    int lat, n; bit h, m; logic [31:0] rd;
    l2_delay = 1000;
    @(negedge clk);
    cache_read_request = 1; cache_L1_memory_address = 32'hC000_0020;
    @(posedge clk); #1;
    cache_read_request = 0;
    n = 0;
    while (read_from_L2_request !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (read_from_L2_request !== 1'b1) begin errors++;
      $display("FAIL reach_allocate: got req=%b expected 1", read_from_L2_request); end
    #2 reset = 0;
    #1;
    checks++; if (read_from_L2_request !== 1'b0 || hit_count !== 4'd0 || miss_count !== 4'd0) begin
      errors++;
      $display("FAIL async_reset_drop: got req=%b hits=%0d misses=%0d expected 0/0/0",
               read_from_L2_request, hit_count, miss_count); end
    @(negedge clk); reset = 1;
    l2_delay = 3; l2_line = {32'd4, 32'd3, 32'd2, 32'd1};
    txn(0, 32'hC000_0020, 32'h0, lat, h, m, rd);
    checks++; if (m !== 1'b1 || h !== 1'b0 || lat != 5 || rd !== 32'h1) begin errors++;
      $display("FAIL retry_after_reset: got miss=%0b hit=%0b lat=%0d rd=%h expected 1/0/5/1",
               m, h, lat, rd); end
    txn(0, 32'hC000_0010, 32'h0, lat, h, m, rd);
    checks++; if (m !== 1'b1 || miss_count !== 4'd2) begin errors++;
      $display("FAIL valid_cleared: got miss=%0b misses=%0d expected 1/2", m, miss_count); end
  endtask

  task automatic test_saturate();
    int lat, nmiss; bit h, m, to; logic [31:0] rd;
    nmiss = 0; to = 0;
    for (int i = 1; i <= 13; i++) begin
      txn(0, 32'hC000_0030 | (i << 8), 32'h0, lat, h, m, rd);
      if (m) nmiss++;
      if (lat >= 100) to = 1;
    end
    checks++; if (nmiss != 13 || to) begin errors++;
      $display("FAIL saturate_fill: got misses=%0d timeout=%0b expected 13/0", nmiss, to); end
    checks++; if (miss_count !== 4'd15) begin errors++;
      $display("FAIL saturate_reach: got %0d expected 15", miss_count); end
    txn(0, 32'hC000_0E30, 32'h0, lat, h, m, rd);
    checks++; if (m !== 1'b1 || miss_count !== 4'd15 || hit_count !== 4'd0) begin errors++;
      $display("FAIL saturate_hold: got miss=%0b misses=%0d hits=%0d expected 1/15/0",
               m, miss_count, hit_count); end
  endtask

  initial begin
    reset = 0; cache_read_request = 0; cache_write_request = 0;
    cache_L1_memory_address = '0; cache_write_data = '0;
    test_reset();
    test_read_miss();
    test_write_hit();
    test_evict();
    test_foreign_id();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
